// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback-source encodings, handshake FSM states and
// the data-memory timeout length used when MEM_WB_TIMEOUT_EN is defined.
package cpu_pkg;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_DM  = 2'b01;
  localparam logic [1:0] SEL_B   = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  localparam int TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_wb_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/dm_if_fsm.sv
// Data-memory handshake controller: IDLE/BUSY tracking, request and stall
// generation. Optional access timeout enabled by macro MEM_WB_TIMEOUT_EN.
module dm_if_fsm
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic dm_ack,
  output logic dm_req,
  output logic mem_stall,
  output logic timeout,
  output logic dm_err
);

  state_t state;
  state_t state_next;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (access && !dm_ack) state_next = ST_BUSY;
      ST_BUSY: if (dm_ack || timeout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Reset kills any outstanding request immediately, so a late ack finds IDLE.
  assign dm_req    = !rst && ((state == ST_IDLE && access) || state == ST_BUSY);
  assign mem_stall = dm_req && !dm_ack && !timeout;

`ifdef MEM_WB_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       err_q;

  assign timeout = (state == ST_BUSY) && !dm_ack &&
                   (wait_cnt == 4'(TIMEOUT_CYCLES - 1));
  assign dm_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_next == ST_IDLE)
        wait_cnt <= '0;
      else if (state == ST_BUSY && !dm_ack)
        wait_cnt <= wait_cnt + 4'd1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign dm_err  = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives the data-memory bus, selects writeback data and
// registers the WB outputs. Timeout support via macro MEM_WB_TIMEOUT_EN.
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_VALID,
  input  logic                  MEM_DM_WE,
  input  logic [31:0]           MEM_ALU_RES,
  input  logic [31:0]           MEM_muxB,
  input  logic [15:0]           MEM_DM_ADDR,
  input  logic [1:0]            MEM_RF_D_SEL,
  input  logic                  MEM_RF_WE,
  input  logic [4:0]            MEM_RF_WA,
  mem_wb_stage_if.master        dm,
  output logic                  MEM_STALL,
  output logic                  WB_VALID,
  output logic                  WB_RF_WE,
  output logic [4:0]            WB_RF_WA,
  output logic [31:0]           WB_RF_D,
  output logic                  DM_ERR
);

  logic        access;
  logic        dm_req;
  logic        timeout;
  logic [31:0] wb_d;

  assign access = MEM_VALID && (MEM_DM_WE || MEM_RF_D_SEL == SEL_DM);

  dm_if_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .access    (access),
    .dm_ack    (dm.dm_ack),
    .dm_req    (dm_req),
    .mem_stall (MEM_STALL),
    .timeout   (timeout),
    .dm_err    (DM_ERR)
  );

  // Bus fields are zeroed whenever no request is outstanding.
  assign dm.dm_req   = dm_req;
  assign dm.dm_we    = dm_req && MEM_DM_WE;
  assign dm.dm_addr  = dm_req ? MEM_DM_ADDR : 16'h0000;
  assign dm.dm_wdata = dm_req ? MEM_muxB    : 32'h0000_0000;

  always_comb begin
    wb_d = MEM_ALU_RES;
    case (MEM_RF_D_SEL)
      SEL_DM:  wb_d = dm.dm_rdata;
      SEL_B:   wb_d = MEM_muxB;
      default: wb_d = MEM_ALU_RES;
    endcase
  end

  // A stalled cycle inserts a bubble; a timed-out access retires without writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_VALID <= 1'b0;
      WB_RF_WE <= 1'b0;
      WB_RF_WA <= '0;
      WB_RF_D  <= '0;
    end else if (MEM_STALL) begin
      WB_VALID <= 1'b0;
      WB_RF_WE <= 1'b0;
    end else begin
      WB_VALID <= MEM_VALID;
      WB_RF_WE <= MEM_VALID && MEM_RF_WE && !MEM_DM_WE && !timeout;
      WB_RF_WA <= MEM_RF_WA;
      WB_RF_D  <= wb_d;
    end
  end

endmodule
